ready_responder: RTL and testbench

// - Responder side of the req/ready completion handshake. Generates the registered

---
 rtl/ready_responder.sv | 193 +++++++++++++++++++
 tb/tb_ready_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ready_responder.sv
// ready_responder
//
// Responder side of a four-phase req/ready completion handshake. The
// initiator raises req_i, ready_o rises LATENCY clock edges later, the
// initiator drops req_i and ready_o falls on that same edge. Every output
// is registered, so ready_o has exactly one clean 0->1 transition for each
// completed handshake.
//
// Build option: define READY_TIMEOUT_EN to bound how long ready_o may stay
// high. If ready_o has been high for TIMEOUT cycles while req_i is still
// high, sticky err_o is raised and the handshake is abandoned. req_i must
// then be seen low before another request is accepted. Without the macro,
// err_o is tied low and READY is held for as long as req_i stays high.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no handshake open; waiting for req_i
// DELAY | request accepted; dcnt counts down the remaining latency
// READY | ready_o high; waiting for the initiator to drop req_i

module ready_responder #(
   parameter int LATENCY = 4,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] done_cnt_o,
   output logic [CNT_W-1:0] abort_cnt_o,
   output logic             err_o
);

   // LATENCY-2 is at most 253, so eight bits always hold the delay count.
   localparam int DCNT_W = 8;
   localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

   if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
      $error("ready_responder: LATENCY must be in 1..255");
   end

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("ready_responder: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   done_q, done_d;
   logic [CNT_W-1:0]   abort_q, abort_d;
   logic               start;

`ifdef READY_TIMEOUT_EN
   // The counter holds TIMEOUT-1 down to 0; a width of at least one bit is kept for TIMEOUT==1.
   localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TIMEOUT - 1);

   logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
   logic               err_q, err_d;
   logic               rearm_wait_q, rearm_wait_d;
`endif

   // Next state, counters and registered-output values for this edge.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      done_d  = done_q;
      abort_d = abort_q;
      start   = 1'b0;
`ifdef READY_TIMEOUT_EN
      tcnt_d       = tcnt_q;
      err_d        = err_q;
      rearm_wait_d = rearm_wait_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef READY_TIMEOUT_EN
            // After a timeout, a request is only taken once req_i has been seen low.
            if (!req_i) begin
               rearm_wait_d = 1'b0;
            end
            start = req_i && !rearm_wait_q;
`else
            start = req_i;
`endif
            if (start) begin
               if (LATENCY == 1) begin
                  state_d = ST_READY;
`ifdef READY_TIMEOUT_EN
                  tcnt_d  = TCNT_LOAD;
`endif
               end else begin
                  state_d = ST_DELAY;
                  dcnt_d  = DCNT_LOAD;
               end
            end
         end

         ST_DELAY: begin
            // A withdrawn request wins over an expiring delay.
            if (!req_i) begin
               state_d = ST_IDLE;
               abort_d = abort_q + CNT_W'(1);
            end else if (dcnt_q == '0) begin
               state_d = ST_READY;
`ifdef READY_TIMEOUT_EN
               tcnt_d  = TCNT_LOAD;
`endif
            end else begin
               dcnt_d = dcnt_q - DCNT_W'(1);
            end
         end

         ST_READY: begin
            if (!req_i) begin
               state_d = ST_IDLE;
               done_d  = done_q + CNT_W'(1);
`ifdef READY_TIMEOUT_EN
            end else if (tcnt_q == '0) begin
               // Abandoned handshake: no completion is counted.
               state_d      = ST_IDLE;
               err_d        = 1'b1;
               rearm_wait_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q - TCNT_W'(1);
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs come from the next state so they change on the same edge as the FSM.
      ready_d = (state_d == ST_READY);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers; reset discards any open handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dcnt_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= '0;
         abort_q <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

`ifdef READY_TIMEOUT_EN
   // Timeout counter, sticky error flag and the re-arm guard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q       <= '0;
         err_q        <= 1'b0;
         rearm_wait_q <= 1'b0;
      end else begin
         tcnt_q       <= tcnt_d;
         err_q        <= err_d;
         rearm_wait_q <= rearm_wait_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign ready_o     = ready_q;
   assign busy_o      = busy_q;
   assign done_cnt_o  = done_q;
   assign abort_cnt_o = abort_q;

endmodule

// File: tb/tb_ready_responder.sv
// Bench for ready_responder: a LATENCY=4 instance checked cycle by cycle
// against a handshake-level model, plus a LATENCY=1 instance for the
// back-to-back and counter-wrap scenario.

module tb_ready_responder;

   localparam int LAT     = 4;
   localparam int TIMEOUT = 64;
`ifdef READY_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       req;
   logic       ready_o, busy_o, err_o;
   logic [7:0] done_o, abort_o;
   logic       req1;
   logic       ready1_o, busy1_o, err1_o;
   logic [7:0] done1_o, abort1_o;

   int n_cmp  = 0;
   int n_fail = 0;

   ready_responder #(.LATENCY(LAT), .CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_i(req), .ready_o(ready_o), .busy_o(busy_o),
      .done_cnt_o(done_o), .abort_cnt_o(abort_o), .err_o(err_o)
   );

   ready_responder #(.LATENCY(1), .CNT_W(8), .TIMEOUT(TIMEOUT)) dut1 (
      .clk(clk), .rst(rst), .req_i(req1), .ready_o(ready1_o), .busy_o(busy1_o),
      .done_cnt_o(done1_o), .abort_cnt_o(abort1_o), .err_o(err1_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges of the LATENCY=1 instance's ready flag.
   int rises1 = 0;
   bit count_rises = 1'b0;
   always @(posedge ready1_o) if (count_rises) rises1++;

   // Handshake-level model: a request is "open" from the edge it is accepted;
   // ready is due once it has been held for LAT sampled edges.
   bit m_act, m_block, m_err;
   int m_age, m_hi, m_done, m_abort;

   task automatic model_reset();
      m_act = 0; m_block = 0; m_err = 0;
      m_age = 0; m_hi = 0; m_done = 0; m_abort = 0;
   endtask

   task automatic model_edge(input logic r);
      if (!m_act) begin
         if (!r) m_block = 0;
         else if (!m_block) begin
            m_act = 1; m_age = 1; m_hi = (m_age >= LAT) ? 1 : 0;
         end
      end else if (!r) begin
         if (m_hi > 0) m_done++;
         else m_abort++;
         m_act = 0;
      end else if (TO_EN && m_hi == TIMEOUT) begin
         m_err = 1; m_act = 0; m_block = 1;
      end else begin
         m_age++;
         if (m_age >= LAT) m_hi++;
      end
   endtask

   function automatic logic exp_ready();
      return m_act && (m_hi > 0);
   endfunction

   // Drive both request lines away from the edge, step the model, sample 1 after the edge.
   task automatic tick(input logic r, input logic r1);
      @(negedge clk);
      req = r; req1 = r1;
      @(posedge clk);
      model_edge(r);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      n_cmp++; if (done_o !== 8'd0 || abort_o !== 8'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", done_o, abort_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 4; i++) begin
         tick(1'b1, 1'b0);
         n_cmp++;
         if (ready_o !== ((i == 4) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL reset_release_ready edge=%0d got=%b exp=%b", i, ready_o, (i == 4));
         end
      end
      tick(1'b0, 1'b0);
      n_cmp++; if (done_o !== 8'd1) begin n_fail++; $display("FAIL reset_release_done got=%0d exp=1", done_o); end
   endtask

   task automatic test_basic();
      int d0;
      d0 = m_done;
      for (int e = 0; e <= 10; e++) begin
         tick((e < 10) ? 1'b1 : 1'b0, 1'b0);
         n_cmp++;
         if (ready_o !== ((e >= 3 && e < 10) ? 1'b1 : 1'b0) || ready_o !== exp_ready()) begin
            n_fail++; $display("FAIL basic_ready edge=%0d got=%b model=%b", e, ready_o, exp_ready());
         end
         n_cmp++;
         if (busy_o !== ((e < 10) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL basic_busy edge=%0d got=%b exp=%b", e, busy_o, (e < 10));
         end
      end
      n_cmp++; if (done_o !== 8'(d0 + 1)) begin n_fail++; $display("FAIL basic_done got=%0d exp=%0d", done_o, d0 + 1); end
   endtask

   task automatic test_abort();
      int d0, a0;
      d0 = m_done; a0 = m_abort;
      tick(1'b0, 1'b0);
      for (int e = 0; e < 3; e++) begin
         tick((e < 2) ? 1'b1 : 1'b0, 1'b0);
         n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL abort_ready edge=%0d got=%b exp=0", e, ready_o); end
      end
      n_cmp++; if (abort_o !== 8'(a0 + 1)) begin n_fail++; $display("FAIL abort_cnt got=%0d exp=%0d", abort_o, a0 + 1); end
      n_cmp++; if (done_o !== 8'(d0)) begin n_fail++; $display("FAIL abort_done got=%0d exp=%0d", done_o, d0); end
   endtask

   task automatic test_toggle();
      int a0;
      a0 = m_abort;
      for (int e = 0; e < 20; e++) begin
         tick(e[0] ? 1'b0 : 1'b1, 1'b0);
         n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL toggle_ready edge=%0d got=%b exp=0", e, ready_o); end
      end
      n_cmp++; if (abort_o !== 8'(a0 + 10)) begin n_fail++; $display("FAIL toggle_abort got=%0d exp=%0d", abort_o, a0 + 10); end
   endtask

   task automatic test_random();
      logic r;
      r = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 4) == 0) r = ~r;
         tick(r, 1'b0);
         n_cmp++;
         if (ready_o !== exp_ready() || busy_o !== m_act || err_o !== m_err) begin
            n_fail++; $display("FAIL random_flags cyc=%0d got=%b%b%b exp=%b%b%b", c, ready_o, busy_o, err_o, exp_ready(), m_act, m_err);
         end
         n_cmp++;
         if (done_o !== 8'(m_done) || abort_o !== 8'(m_abort)) begin
            n_fail++; $display("FAIL random_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", c, done_o, abort_o, 8'(m_done), 8'(m_abort));
         end
      end
   endtask

   task automatic test_async_mid_ready();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int e = 0; e < 6; e++) tick(1'b1, 1'b0);
      n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL async_pre_ready got=%b exp=1", ready_o); end
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (ready_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL async_flags got=%b%b exp=00", ready_o, busy_o); end
      n_cmp++; if (done_o !== 8'd0 || abort_o !== 8'd0) begin n_fail++; $display("FAIL async_counts got=%0d/%0d exp=0/0", done_o, abort_o); end
      @(posedge clk); #1;
      req = 1'b0;
      rst = 1'b0;
      model_reset();
      tick(1'b0, 1'b0);
      n_cmp++; if (done_o !== 8'd0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL async_after got=%0d/%b exp=0/0", done_o, ready_o); end
   endtask

   task automatic test_back_to_back();
      count_rises = 1'b1;
      for (int h = 0; h < 300; h++) begin
         for (int p = 0; p < 4; p++) begin
            tick(1'b0, (p < 3) ? 1'b1 : 1'b0);
            n_cmp++;
            if (ready1_o !== ((p < 3) ? 1'b1 : 1'b0)) begin
               n_fail++; $display("FAIL b2b_ready hs=%0d ph=%0d got=%b exp=%b", h, p, ready1_o, (p < 3));
            end
         end
      end
      count_rises = 1'b0;
      n_cmp++; if (rises1 !== 300) begin n_fail++; $display("FAIL b2b_rises got=%0d exp=300", rises1); end
      n_cmp++; if (done1_o !== 8'd44) begin n_fail++; $display("FAIL b2b_done got=%0d exp=44", done1_o); end
      n_cmp++; if (abort1_o !== 8'd0) begin n_fail++; $display("FAIL b2b_abort got=%0d exp=0", abort1_o); end
   endtask

`ifdef READY_TIMEOUT_EN
   task automatic test_timeout();
      int d0, hi_cycles;
      d0 = m_done;
      hi_cycles = 0;
      tick(1'b0, 1'b0);
      for (int e = 0; e < LAT + TIMEOUT + 10; e++) begin
         tick(1'b1, 1'b0);
         if (ready_o === 1'b1) hi_cycles++;
         n_cmp++;
         if (ready_o !== exp_ready() || err_o !== m_err) begin
            n_fail++; $display("FAIL timeout_flags edge=%0d got=%b%b exp=%b%b", e, ready_o, err_o, exp_ready(), m_err);
         end
      end
      n_cmp++; if (hi_cycles !== TIMEOUT) begin n_fail++; $display("FAIL timeout_len got=%0d exp=%0d", hi_cycles, TIMEOUT); end
      n_cmp++; if (err_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL timeout_end got=%b%b exp=10", err_o, ready_o); end
      n_cmp++; if (done_o !== 8'(d0)) begin n_fail++; $display("FAIL timeout_done got=%0d exp=%0d", done_o, d0); end
      tick(1'b0, 1'b0);
      for (int e = 1; e <= LAT; e++) begin
         tick(1'b1, 1'b0);
         n_cmp++;
         if (ready_o !== ((e == LAT) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL timeout_rearm edge=%0d got=%b exp=%b", e, ready_o, (e == LAT));
         end
      end
      n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=1", err_o); end
      tick(1'b0, 1'b0);
   endtask
`endif

   initial begin
      rst = 1'b1; req = 1'b0; req1 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_basic();
      test_abort();
      test_toggle();
      test_random();
      test_async_mid_ready();
      test_back_to_back();
`ifdef READY_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
